// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester arbiter.
//   NUM_REQ / ID_W : requester count and owner-index width
//   arb_state_e    : FSM encoding (ST_IDLE = 0, ST_GRANT = 1)
//   id_to_onehot   : binary owner index -> one-hot grant vector
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational downward wrapping priority search over four requests.
//   req   : request vector
//   start : index searched first (round-robin mode only)
//   mode  : 0 = fixed priority (search starts at 3), 1 = start at 'start'
//   found : any request set
//   id    : first set index found searching start, start-1, ... wrapping 0 -> 3
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  input  logic               mode,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] base;
  logic [ID_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = '0;
    base  = mode ? start : ID_W'(NUM_REQ - 1);
    // Walk from the lowest-priority position up to 'base' so the last hit
    // (closest to base) wins; index arithmetic wraps naturally in ID_W bits.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = base - ID_W'(i);
      if (req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection and
// optional forced release after MAX_HOLD grant cycles under contention.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   mode      : 0 = fixed priority, 1 = round-robin (sampled at selection)
//   req[3:0]  : level-sensitive requests
//   gnt[3:0]  : registered one-hot grant
//   gnt_valid : OR of gnt
//   gnt_id    : binary owner index, 0 when no grant
//   preempt   : one-cycle pulse on the idle cycle following a forced release
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       preempt
);

  localparam bit HoldEn = (MAX_HOLD != 0);
  // Counter ceiling; with unlimited hold it simply parks at all-ones.
  localparam logic [CNT_W-1:0] HoldLast = HoldEn ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               preempt_q, preempt_d;

  logic [ID_W-1:0] rr_start;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            owner_req;
  logic            others_pending;
  logic            force_rel;

  // Round-robin search begins just below the previous owner.
  assign rr_start = last_id_q - ID_W'(1);

  rr_pick4 u_pick (
    .req   (req),
    .start (rr_start),
    .mode  (mode),
    .found (pick_found),
    .id    (pick_id)
  );

  assign owner_req      = req[gnt_id_q];
  assign others_pending = |(req & ~gnt_q);
  assign force_rel      = HoldEn && (hold_cnt_q == HoldLast) && others_pending;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          gnt_d      = id_to_onehot(pick_id);
          gnt_id_d   = pick_id;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || force_rel) begin
          state_d    = ST_IDLE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          last_id_d  = gnt_id_q;
          hold_cnt_d = '0;
          // An owner that drops on the same cycle counts as a voluntary release.
          preempt_d  = owner_req;
        end else if (hold_cnt_q != HoldLast) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      last_id_q  <= '0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule
